uart_debug_tx: RTL and testbench

Debug UART transmitter, the stage directly downstream of the debug baud generator.
- Accepts bytes over a valid/ready handshake into a one-entry holding register.
- Serialises each byte as an asynchronous frame on txd, advancing exactly one bit per baud_en pulse.
- Sits between the watchdog debug logic, which produces bytes, and the board debug pin.

---
 rtl/uart_debug_pkg.sv | 18 +
 rtl/uart_debug_tx.sv | 171 +++++++++++++++++
 tb/tb_uart_debug_tx.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_debug_pkg.sv
// Shared constants for the debug UART transmitter: one-hot FSM encoding,
// idle line level and bit-counter width.
package uart_debug_pkg;

    localparam int unsigned ST_W  = 5;
    localparam int unsigned CNT_W = 3;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE   = 5'b00001;
    localparam state_t ST_START  = 5'b00010;
    localparam state_t ST_DATA   = 5'b00100;
    localparam state_t ST_PARITY = 5'b01000;
    localparam state_t ST_STOP   = 5'b10000;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_debug_tx.sv
// Debug UART transmitter: one-entry holding register feeding a shifter that
// advances one bit per baud_en. Parity stage compiled in with UART_DEBUG_PARITY_EN.
module uart_debug_tx
    import uart_debug_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              ref_clk,
    input  logic              rst_n,
    input  logic              baud_en,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    output logic              tx_busy
);

    if (DATA_W < 5 || DATA_W > 8 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1)
    begin : g_param_check
        $error("uart_debug_tx: unsupported parameter combination");
    end

    state_t            state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              hold_full_q, hold_full_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              txd_d, tx_ready_d, tx_busy_d;
    logic              xfer, load, data_last, stop_last;
`ifdef UART_DEBUG_PARITY_EN
    logic              par_q, par_d;
`endif

    assign xfer      = tx_valid & tx_ready;
    assign data_last = (cnt_q == CNT_W'(DATA_W - 1));
    assign stop_last = (cnt_q == CNT_W'(STOP_BITS - 1));

    // State register
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every transition is gated by baud_en
    always_comb begin
        state_d = state_q;
        if (baud_en) begin
            case (state_q)
                ST_IDLE:   if (hold_full_q) state_d = ST_START;
                ST_START:  state_d = ST_DATA;
`ifdef UART_DEBUG_PARITY_EN
                ST_DATA:   if (data_last) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
`else
                ST_DATA:   if (data_last) state_d = ST_STOP;
`endif
                ST_STOP:   if (stop_last) state_d = hold_full_q ? ST_START : ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        txd_d   = txd;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
`ifdef UART_DEBUG_PARITY_EN
        par_d   = par_q;
`endif
        if (baud_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (hold_full_q) begin
                        load  = 1'b1;
                        txd_d = 1'b0;
                    end
                end
                ST_START: begin
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    cnt_d   = '0;
                end
                ST_DATA: begin
                    if (!data_last) begin
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[DATA_W-1:1]};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
`ifdef UART_DEBUG_PARITY_EN
                        txd_d = par_q;
`else
                        txd_d = IDLE_LEVEL;
`endif
                        cnt_d = '0;
                    end
                end
`ifdef UART_DEBUG_PARITY_EN
                ST_PARITY: begin
                    txd_d = IDLE_LEVEL;
                    cnt_d = '0;
                end
`endif
                ST_STOP: begin
                    if (stop_last) begin
                        cnt_d = '0;
                        if (hold_full_q) begin
                            load  = 1'b1;
                            txd_d = 1'b0;
                        end else begin
                            txd_d = IDLE_LEVEL;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    txd_d = IDLE_LEVEL;
                    cnt_d = '0;
                end
            endcase
        end

        if (load) begin
            shift_d = hold_q;
`ifdef UART_DEBUG_PARITY_EN
            par_d   = (^hold_q) ^ 1'(PARITY_ODD);
`endif
        end

        // A load and a new transfer may share an edge; the new byte refills the holder
        hold_full_d = (hold_full_q & ~load) | xfer;
        hold_d      = xfer ? tx_data : hold_q;
        tx_ready_d  = ~hold_full_d;
        tx_busy_d   = (state_d != ST_IDLE) | hold_full_d;
    end

    // Datapath and registered outputs
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            txd         <= IDLE_LEVEL;
            tx_ready    <= 1'b1;
            tx_busy     <= 1'b0;
`ifdef UART_DEBUG_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            txd         <= txd_d;
            tx_ready    <= tx_ready_d;
            tx_busy     <= tx_busy_d;
`ifdef UART_DEBUG_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_debug_tx.sv
// Self-checking bench for uart_debug_tx: frame-level line model checked every
// cycle, plus literal frame checks. Honours UART_DEBUG_PARITY_EN.
module tb_uart_debug_tx;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned STOP_BITS  = 1;
    localparam int unsigned PARITY_ODD = 0;
`ifdef UART_DEBUG_PARITY_EN
    localparam int FL = 11;
    localparam logic [31:0] EXP_55   = 32'({1'b1, 1'b0, 8'h55, 1'b0});
    localparam logic [31:0] EXP_FF   = 32'({1'b1, 1'b0, 8'hFF, 1'b0});
    localparam logic [31:0] EXP_B2B  = 32'({1'b1, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b0, 8'hA3, 1'b0});
    localparam logic [31:0] EXP_81   = 32'({1'b1, 1'b0, 8'h81, 1'b0});
    localparam logic [31:0] EXP_07   = 32'({1'b1, 1'b1, 8'h07, 1'b0});
`else
    localparam int FL = 10;
    localparam logic [31:0] EXP_55   = 32'({1'b1, 8'h55, 1'b0});
    localparam logic [31:0] EXP_FF   = 32'({1'b1, 8'hFF, 1'b0});
    localparam logic [31:0] EXP_B2B  = 32'({1'b1, 8'h0F, 1'b0, 1'b1, 8'hA3, 1'b0});
    localparam logic [31:0] EXP_81   = 32'({1'b1, 8'h81, 1'b0});
`endif

    logic              ref_clk = 1'b0;
    logic              rst_n   = 1'b1;
    logic              baud_en = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready, txd, tx_busy;

    int n_cmp = 0;
    int n_err = 0;
    int baud_div = 4;

    // Model: pending line bits of the current frame plus a one-byte holder
    logic       m_txd      = 1'b1;
    logic       m_hold_v   = 1'b0;
    logic       m_in_frame = 1'b0;
    logic [7:0] m_hold     = '0;
    bit         m_line[$];

    uart_debug_tx #(
        .DATA_W    (DATA_W),
        .STOP_BITS (STOP_BITS),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .ref_clk (ref_clk),
        .rst_n   (rst_n),
        .baud_en (baud_en),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .txd     (txd),
        .tx_busy (tx_busy)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit xfer;
        xfer = tx_valid && !m_hold_v;
        if (baud_en) begin
            if (m_line.size() > 0) begin
                m_txd = m_line.pop_front();
            end else if (m_hold_v) begin
                bit par;
                par = 1'(PARITY_ODD);
                m_line.push_back(1'b0);
                for (int i = 0; i < int'(DATA_W); i++) begin
                    m_line.push_back(m_hold[i]);
                    par ^= m_hold[i];
                end
`ifdef UART_DEBUG_PARITY_EN
                m_line.push_back(par);
`endif
                for (int i = 0; i < int'(STOP_BITS); i++) m_line.push_back(1'b1);
                m_hold_v   = 1'b0;
                m_in_frame = 1'b1;
                m_txd      = m_line.pop_front();
            end else begin
                m_txd      = 1'b1;
                m_in_frame = 1'b0;
            end
        end
        if (xfer) begin
            m_hold   = tx_data;
            m_hold_v = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(posedge ref_clk); #1;
        while (!tx_ready && n < 3000) begin
            @(posedge ref_clk); #1;
            n++;
        end
        chk("send_ready_seen", 32'(tx_ready), 32'(1));
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge ref_clk); #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Waits for a start bit, then records one sample per bit period
    task automatic capture(input int bpc, input int nper, output logic [31:0] bits,
                           output logic stable);
        int n = 0;
        logic v;
        bits   = '0;
        stable = 1'b1;
        @(negedge ref_clk);
        while (txd !== 1'b0 && n < 3000) begin
            @(negedge ref_clk);
            n++;
        end
        chk("start_bit_seen", 32'(txd), 32'(0));
        for (int k = 0; k < nper; k++) begin
            for (int c = 0; c < bpc; c++) begin
                if (k != 0 || c != 0) @(negedge ref_clk);
                v = txd;
                if (c == 0) bits[k] = v;
                else if (v !== bits[k]) stable = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge ref_clk);
        while (tx_busy && n < 3000) begin
            @(negedge ref_clk);
            n++;
        end
        chk("idle_reached", 32'(tx_busy), 32'(0));
    endtask

    initial begin
        logic [31:0] bits;
        logic        st;
        logic        rdy;
        int          n;

        #2 rst_n = 1'b0;

        fork
            forever begin
                @(posedge ref_clk or negedge rst_n);
                if (!rst_n) begin
                    m_txd = 1'b1; m_hold_v = 1'b0; m_in_frame = 1'b0;
                    m_line.delete();
                end else begin
                    model_step();
                end
            end
            begin
                int bcnt = 0;
                forever begin
                    @(posedge ref_clk); #1;
                    if (baud_div == 0) baud_en = ($urandom_range(0, 2) == 0);
                    else begin
                        bcnt    = (bcnt + 1) % baud_div;
                        baud_en = (bcnt == 0);
                    end
                end
            end
            forever begin
                @(negedge ref_clk);
                chk("txd", 32'(txd), 32'(m_txd));
                chk("tx_ready", 32'(tx_ready), 32'(!m_hold_v));
                chk("tx_busy", 32'(tx_busy), 32'(m_in_frame | m_hold_v));
            end
        join_none

        @(negedge ref_clk); #1;
        chk("rst_txd", 32'(txd), 32'(1));
        chk("rst_ready", 32'(tx_ready), 32'(1));
        chk("rst_busy", 32'(tx_busy), 32'(0));
        @(posedge ref_clk); #3 rst_n = 1'b1;

        // 0x55, one bit every 4 clocks
        baud_div = 4;
        send_byte(8'h55);
        capture(4, FL, bits, st);
        chk("frame_55", bits, EXP_55);
        chk("hold_4_cycles", 32'(st), 32'(1));
        chk("busy_last_stop", 32'(tx_busy), 32'(1));
        @(negedge ref_clk);
        chk("busy_after_stop", 32'(tx_busy), 32'(0));

        // baud_en held high, 0xFF
        baud_div = 1;
        send_byte(8'hFF);
        capture(1, FL, bits, st);
        chk("frame_ff", bits, EXP_FF);
        wait_idle();

        // back-to-back 0xA3 then 0x0F, second offered while first shifts
        baud_div = 4;
        fork
            begin
                send_byte(8'hA3);
                repeat (6) @(posedge ref_clk);
                send_byte(8'h0F);
            end
            capture(4, 2 * FL, bits, st);
        join
        chk("frame_b2b", bits, EXP_B2B);
        chk("b2b_stable", 32'(st), 32'(1));
        wait_idle();

`ifdef UART_DEBUG_PARITY_EN
        baud_div = 1;
        send_byte(8'h07);
        capture(1, FL, bits, st);
        chk("frame_07_parity", bits, EXP_07);
        wait_idle();
        baud_div = 4;
`endif

        // reset during data bit 3 of 0x3C
        send_byte(8'h3C);
        n = 0;
        @(negedge ref_clk);
        while (txd !== 1'b0 && n < 3000) begin
            @(negedge ref_clk);
            n++;
        end
        repeat (17) @(negedge ref_clk);
        chk("bit3_of_3c", 32'(txd), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_txd", 32'(txd), 32'(1));
        chk("midrst_ready", 32'(tx_ready), 32'(1));
        chk("midrst_busy", 32'(tx_busy), 32'(0));
        repeat (2) @(negedge ref_clk);
        #2 rst_n = 1'b1;
        send_byte(8'h81);
        capture(4, FL, bits, st);
        chk("frame_81_after_rst", bits, EXP_81);
        wait_idle();

        // random traffic, random baud pacing, data wiggled while stalled
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) begin
                case ($urandom_range(0, 4))
                    0: baud_div = 0;
                    1: baud_div = 1;
                    2: baud_div = 2;
                    3: baud_div = 3;
                    default: baud_div = 5;
                endcase
            end
            repeat ($urandom_range(0, 12)) @(posedge ref_clk);
            @(posedge ref_clk); #1;
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
            rdy = tx_ready;
            n = 0;
            @(posedge ref_clk); #1;
            while (!rdy && n < 3000) begin
                if ($urandom_range(0, 3) == 0) tx_data = 8'($urandom);
                rdy = tx_ready;
                @(posedge ref_clk); #1;
                n++;
            end
            tx_valid = 1'b0;
            if (n >= 3000) chk("rand_accept", 32'(rdy), 32'(1));
        end
        wait_idle();
        repeat (3) @(negedge ref_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
